// File: rtl/core_lsu.sv
// core_lsu: MEM-stage load/store unit driving a handshaked data bus.
// Handles byte/half/word/dword accesses, byte enables, misalignment,
// bus timeout and pipeline flush.
module core_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  input  logic                flush,
  output logic                stall,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_we,
  output logic                exc_misaligned,
  output logic                exc_bus,
  output logic                d_req,
  output logic                d_we,
  output logic [XLEN-1:0]     d_addr,
  output logic [XLEN/8-1:0]   d_be,
  output logic [XLEN-1:0]     d_wdata,
  input  logic                d_gnt,
  input  logic                d_rvalid,
  input  logic [XLEN-1:0]     d_rdata
);
  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int CNTW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, next_state;
  logic [CNTW-1:0]   cnt;
  logic              flushed_q;
  logic              we_q, sgn_q;
  logic [1:0]        size_q;
  logic [OFFW-1:0]   off_q;
  logic [4:0]        rd_q;
  logic              resp_valid_q, resp_we_q, exc_mis_q, exc_bus_q;

  logic accept, req_illegal, timed_out, flush_seen, awaiting;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = low[0];
      2'd2:    bad = |low[1:0];
      default: bad = |low[2:0] || (XLEN == 32);
    endcase
    return bad;
  endfunction

  function automatic logic [LANES-1:0] be_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return LANES'(m) << off;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] data,
                                                   input logic [OFFW-1:0] off,
                                                   input logic [1:0] size,
                                                   input logic sgn);
    logic [XLEN-1:0] sh, keep;
    logic            msb;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    begin keep = XLEN'(8'hFF);         msb = sh[7];  end
      2'd1:    begin keep = XLEN'(16'hFFFF);      msb = sh[15]; end
      2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); msb = sh[31]; end
      default: begin keep = '1;                   msb = 1'b0;   end
    endcase
    return (sh & keep) | ((sgn & msb) ? ~keep : '0);
  endfunction

  assign accept      = (state == IDLE) && req_valid && !flush;
  assign req_illegal = is_misaligned(req_size, req_addr[2:0]);
  assign timed_out   = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign flush_seen  = flushed_q || flush;
  // The awaited bus event (grant in REQ, read data in WAIT) is absent this cycle.
  assign awaiting    = ((state == REQ) && !d_gnt) || ((state == WAIT) && !d_rvalid);

  // State register, timeout counter and sticky flush flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      flushed_q <= 1'b0;
    end else begin
      state <= next_state;
      if ((next_state != state) && ((next_state == REQ) || (next_state == WAIT)))
        cnt <= '0;
      else if (awaiting && (TIMEOUT != 0))
        cnt <= cnt + 1'b1;
      if (state == IDLE)
        flushed_q <= 1'b0;
      else if (((state == REQ) || (state == WAIT)) && flush)
        flushed_q <= 1'b1;
    end
  end

  // Next-state decision; a flushed access that still completes on the bus returns straight to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = req_illegal ? DONE : REQ;
      REQ: begin
        if (d_gnt) begin
          if (!we_q && !d_rvalid) next_state = WAIT;
          else                    next_state = flush_seen ? IDLE : DONE;
        end else if (flush) begin
          next_state = IDLE;
        end else if (timed_out) begin
          next_state = DONE;
        end
      end
      WAIT: if (d_rvalid || timed_out) next_state = flush_seen ? IDLE : DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stall and flush-gated completion outputs.
  always_comb begin
    stall          = reset && ((state == REQ) || (state == WAIT) || accept);
    resp_valid     = resp_valid_q && !flush;
    resp_we        = resp_we_q && !flush;
    exc_misaligned = exc_mis_q && !flush;
    exc_bus        = exc_bus_q && !flush;
  end

  // Request fields kept for the duration of the access.
  always_ff @(posedge clock) begin
    if (accept) begin
      we_q   <= req_we;
      sgn_q  <= req_signed;
      size_q <= req_size;
      off_q  <= req_addr[OFFW-1:0];
      rd_q   <= req_rd;
    end
  end

  // Bus-side registers: request strobe follows REQ, payload is loaded on accept and held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_req   <= 1'b0;
      d_we    <= 1'b0;
      d_addr  <= '0;
      d_be    <= '0;
      d_wdata <= '0;
    end else begin
      d_req <= (next_state == REQ);
      if (accept) begin
        d_we    <= req_we;
        d_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        d_be    <= be_mask(req_size, req_addr[OFFW-1:0]);
        d_wdata <= req_wdata << {req_addr[OFFW-1:0], 3'b000};
      end
    end
  end

  // Completion registers, loaded on the transition into DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      exc_mis_q    <= 1'b0;
      exc_bus_q    <= 1'b0;
      resp_data    <= '0;
      resp_rd      <= '0;
    end else begin
      resp_valid_q <= (next_state == DONE);
      exc_mis_q    <= (state == IDLE) && (next_state == DONE);
      exc_bus_q    <= (next_state == DONE) && (state != IDLE) && awaiting;
      resp_we_q    <= (next_state == DONE) && (state != IDLE) && !awaiting && !we_q;
      if ((next_state == DONE) && (state != IDLE) && !awaiting && !we_q) begin
        resp_data <= load_extract(d_rdata, off_q, size_q, sgn_q);
        resp_rd   <= rd_q;
      end else begin
        resp_data <= '0;
        resp_rd   <= '0;
      end
    end
  end

endmodule
